// File: rtl/tlb_op_ctrl_pkg.sv
// Shared TLB types and sizing for the TLB op controller and the mmu.
package tlb_op_ctrl_pkg;

  localparam int unsigned TLB_LINE  = 32;
  localparam int unsigned TLB_WIDTH = 5;

  typedef enum logic [1:0] {
    OpProbe     = 2'd0,
    OpRead      = 2'd1,
    OpWriteIdx  = 2'd2,
    OpWriteRand = 2'd3
  } tlb_op_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StExec   = 2'd1,
    StCommit = 2'd2
  } tlb_ctrl_state_e;

endpackage

// File: rtl/tlb_op_ctrl_if.sv
// MEM-stage request, mmu op/result and cp0 commit signals of the TLB op controller.
interface tlb_op_ctrl_if;
  import tlb_op_ctrl_pkg::*;

  logic        req_valid;
  tlb_op_e     req_op;
  logic        req_ready;
  logic        flush;
  logic        stall;
  logic        done;

  logic        mmu_tlbp;
  logic        mmu_tlbr;
  logic        mmu_tlbwi;
  logic        mmu_tlbwr;
  logic [31:0] mmu_index_in;
  logic [31:0] mmu_entryhi_in;
  logic [31:0] mmu_entrylo0_in;
  logic [31:0] mmu_entrylo1_in;

  logic        cp0_index_we;
  logic        cp0_entry_we;
  logic [31:0] cp0_index_wdata;
  logic [31:0] cp0_entryhi_wdata;
  logic [31:0] cp0_entrylo0_wdata;
  logic [31:0] cp0_entrylo1_wdata;

  modport master (
    output req_valid, req_op, flush,
    output mmu_index_in, mmu_entryhi_in, mmu_entrylo0_in, mmu_entrylo1_in,
    input  req_ready, stall, done,
    input  mmu_tlbp, mmu_tlbr, mmu_tlbwi, mmu_tlbwr,
    input  cp0_index_we, cp0_entry_we,
    input  cp0_index_wdata, cp0_entryhi_wdata, cp0_entrylo0_wdata, cp0_entrylo1_wdata
  );

  modport slave (
    input  req_valid, req_op, flush,
    input  mmu_index_in, mmu_entryhi_in, mmu_entrylo0_in, mmu_entrylo1_in,
    output req_ready, stall, done,
    output mmu_tlbp, mmu_tlbr, mmu_tlbwi, mmu_tlbwr,
    output cp0_index_we, cp0_entry_we,
    output cp0_index_wdata, cp0_entryhi_wdata, cp0_entrylo0_wdata, cp0_entrylo1_wdata
  );

endinterface

// File: rtl/tlb_op_ctrl_random_ctr.sv
// CP0 Random register: free-running decrement from TLB_LINE-1 down to Wired, then wrap.
module tlb_op_ctrl_random_ctr
  import tlb_op_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TLB_WIDTH-1:0] i_wired_in,
  input  logic                 i_wired_we,
  output logic [TLB_WIDTH-1:0] o_random
);

  localparam logic [TLB_WIDTH-1:0] RandMax = TLB_WIDTH'(TLB_LINE - 1);

  logic [TLB_WIDTH-1:0] r_random;

  // Wired at or above the max makes the compare always true, so Random holds at max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_random <= RandMax;
    end else if (i_wired_we || (r_random <= i_wired_in)) begin
      r_random <= RandMax;
    end else begin
      r_random <= r_random - 1'b1;
    end
  end

  assign o_random = r_random;

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR from MEM into the mmu and commits results to CP0.
module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  tlb_op_ctrl_if.slave         bus,
  input  logic [TLB_WIDTH-1:0] i_wired_in,
  input  logic                 i_wired_we,
  output logic [31:0]          o_random_out
);

  tlb_ctrl_state_e r_state;
  tlb_op_e         r_op;
  logic            r_done;
  logic            r_index_we;
  logic            r_entry_we;
  logic [31:0]     r_index;
  logic [31:0]     r_entryhi;
  logic [31:0]     r_entrylo0;
  logic [31:0]     r_entrylo1;

  logic                 w_accept;
  logic                 w_exec_go;
  logic [TLB_WIDTH-1:0] w_random;

  assign w_accept  = (r_state == StIdle) && bus.req_valid && !bus.flush;
  assign w_exec_go = (r_state == StExec) && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_op       <= OpProbe;
      r_done     <= 1'b0;
      r_index_we <= 1'b0;
      r_entry_we <= 1'b0;
      r_index    <= '0;
      r_entryhi  <= '0;
      r_entrylo0 <= '0;
      r_entrylo1 <= '0;
    end else begin
      r_done     <= 1'b0;
      r_index_we <= 1'b0;
      r_entry_we <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_op    <= bus.req_op;
            r_state <= StExec;
          end
        end
        StExec: begin
          // A flush here kills the op before the mmu sees a strobe.
          if (bus.flush) begin
            r_state <= StIdle;
          end else begin
            r_state    <= StCommit;
            r_done     <= 1'b1;
            r_index_we <= (r_op == OpProbe);
            r_entry_we <= (r_op == OpRead);
            if (r_op == OpProbe) r_index <= bus.mmu_index_in;
            if (r_op == OpRead) begin
              r_entryhi  <= bus.mmu_entryhi_in;
              r_entrylo0 <= bus.mmu_entrylo0_in;
              r_entrylo1 <= bus.mmu_entrylo1_in;
            end
          end
        end
        StCommit: r_state <= StIdle;
        default:  r_state <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = (r_state == StIdle);
  assign bus.stall     = (r_state != StIdle) || (bus.req_valid && !bus.flush);
  assign bus.done      = r_done;

  assign bus.mmu_tlbp  = w_exec_go && (r_op == OpProbe);
  assign bus.mmu_tlbr  = w_exec_go && (r_op == OpRead);
  assign bus.mmu_tlbwi = w_exec_go && (r_op == OpWriteIdx);
  assign bus.mmu_tlbwr = w_exec_go && (r_op == OpWriteRand);

  assign bus.cp0_index_we       = r_index_we;
  assign bus.cp0_entry_we       = r_entry_we;
  assign bus.cp0_index_wdata    = r_index;
  assign bus.cp0_entryhi_wdata  = r_entryhi;
  assign bus.cp0_entrylo0_wdata = r_entrylo0;
  assign bus.cp0_entrylo1_wdata = r_entrylo1;

  tlb_op_ctrl_random_ctr u_random_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wired_in (i_wired_in),
    .i_wired_we (i_wired_we),
    .o_random   (w_random)
  );

  assign o_random_out = {{(32 - TLB_WIDTH){1'b0}}, w_random};

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl: op latency, cp0 commit data, flush handling, Random counter.
module tb_tlb_op_ctrl;
  import tlb_op_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [4:0]  wired_in;
  logic        wired_we;
  logic [31:0] random_out;

  int n_tests;
  int n_fail;

  tlb_op_ctrl_if bus ();

  tlb_op_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .i_wired_in   (wired_in),
    .i_wired_we   (wired_we),
    .o_random_out (random_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks run 2ns later, well before the next edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic strobes(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, bus.mmu_tlbp, bus.mmu_tlbr, bus.mmu_tlbwi, bus.mmu_tlbwr}, {28'd0, exp});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    wired_in = 5'd0;
    wired_we = 1'b0;
    bus.req_valid       = 1'b0;
    bus.req_op          = OpProbe;
    bus.flush           = 1'b0;
    bus.mmu_index_in    = 32'h0;
    bus.mmu_entryhi_in  = 32'h0;
    bus.mmu_entrylo0_in = 32'h0;
    bus.mmu_entrylo1_in = 32'h0;

    #12;
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    strobes("rst_strobes", 4'b0000);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_random", random_out, 32'd31);
    check("rst_index_wdata", bus.cp0_index_wdata, 32'd0);
    check("rst_we", {30'd0, bus.cp0_index_we, bus.cp0_entry_we}, 32'd0);
    rst_n = 1'b1;

    // PROBE hit on entry 5
    next_cycle();
    bus.req_valid = 1'b1; bus.req_op = OpProbe; bus.mmu_index_in = 32'h5;
    settle();
    check("p_hit_c0_stall", {31'd0, bus.stall}, 32'd1);
    strobes("p_hit_c0_strobes", 4'b0000);
    next_cycle();
    bus.req_valid = 1'b0;
    settle();
    strobes("p_hit_c1_strobes", 4'b1000);
    check("p_hit_c1_stall", {31'd0, bus.stall}, 32'd1);
    check("p_hit_c1_ready", {31'd0, bus.req_ready}, 32'd0);
    check("p_hit_c1_done", {31'd0, bus.done}, 32'd0);
    next_cycle(); settle();
    check("p_hit_c2_index_we", {31'd0, bus.cp0_index_we}, 32'd1);
    check("p_hit_c2_entry_we", {31'd0, bus.cp0_entry_we}, 32'd0);
    check("p_hit_c2_wdata", bus.cp0_index_wdata, 32'h5);
    check("p_hit_c2_done", {31'd0, bus.done}, 32'd1);
    check("p_hit_c2_stall", {31'd0, bus.stall}, 32'd1);
    strobes("p_hit_c2_strobes", 4'b0000);
    next_cycle(); settle();
    check("p_hit_c3_stall", {31'd0, bus.stall}, 32'd0);
    check("p_hit_c3_done", {31'd0, bus.done}, 32'd0);
    check("p_hit_c3_index_we", {31'd0, bus.cp0_index_we}, 32'd0);
    check("p_hit_c3_ready", {31'd0, bus.req_ready}, 32'd1);

    // PROBE miss
    bus.req_valid = 1'b1; bus.req_op = OpProbe; bus.mmu_index_in = 32'h8000_0000;
    next_cycle();
    bus.req_valid = 1'b0;
    next_cycle(); settle();
    check("p_miss_wdata", bus.cp0_index_wdata, 32'h8000_0000);
    check("p_miss_done", {31'd0, bus.done}, 32'd1);

    // READ entry 3
    next_cycle();
    bus.req_valid = 1'b1; bus.req_op = OpRead;
    bus.mmu_entryhi_in = 32'h1234_5001; bus.mmu_entrylo0_in = 32'h0000_0C1F;
    bus.mmu_entrylo1_in = 32'h0000_1C1F;
    next_cycle();
    bus.req_valid = 1'b0;
    settle();
    strobes("read_c1_strobes", 4'b0100);
    next_cycle(); settle();
    check("read_c2_entry_we", {31'd0, bus.cp0_entry_we}, 32'd1);
    check("read_c2_index_we", {31'd0, bus.cp0_index_we}, 32'd0);
    check("read_c2_hi", bus.cp0_entryhi_wdata, 32'h1234_5001);
    check("read_c2_lo0", bus.cp0_entrylo0_wdata, 32'h0000_0C1F);
    check("read_c2_lo1", bus.cp0_entrylo1_wdata, 32'h0000_1C1F);

    // WRITE_RAND followed back-to-back by WRITE_IDX held on the request
    next_cycle();
    bus.req_valid = 1'b1; bus.req_op = OpWriteRand;
    next_cycle();
    bus.req_op = OpWriteIdx;
    settle();
    strobes("wr_c1_strobes", 4'b0001);
    check("wr_c1_ready", {31'd0, bus.req_ready}, 32'd0);
    next_cycle(); settle();
    check("wr_c2_ready", {31'd0, bus.req_ready}, 32'd0);
    check("wr_c2_done", {31'd0, bus.done}, 32'd1);
    check("wr_c2_we", {30'd0, bus.cp0_index_we, bus.cp0_entry_we}, 32'd0);
    strobes("wr_c2_strobes", 4'b0000);
    next_cycle(); settle();
    check("wr_c3_ready", {31'd0, bus.req_ready}, 32'd1);
    check("wr_c3_stall", {31'd0, bus.stall}, 32'd1);
    next_cycle();
    bus.req_valid = 1'b0;
    settle();
    strobes("wi_c4_strobes", 4'b0010);
    next_cycle(); settle();
    check("wi_c5_done", {31'd0, bus.done}, 32'd1);
    check("wi_c5_we", {30'd0, bus.cp0_index_we, bus.cp0_entry_we}, 32'd0);

    // Flush during EXEC kills the op
    next_cycle();
    bus.req_valid = 1'b1; bus.req_op = OpProbe; bus.mmu_index_in = 32'h7;
    next_cycle();
    bus.req_valid = 1'b0; bus.flush = 1'b1;
    settle();
    strobes("fl_exec_strobes", 4'b0000);
    check("fl_exec_stall", {31'd0, bus.stall}, 32'd1);
    next_cycle();
    bus.flush = 1'b0;
    settle();
    check("fl_exec_ready", {31'd0, bus.req_ready}, 32'd1);
    check("fl_exec_done", {31'd0, bus.done}, 32'd0);
    check("fl_exec_index_we", {31'd0, bus.cp0_index_we}, 32'd0);
    check("fl_exec_wdata", bus.cp0_index_wdata, 32'h8000_0000);
    next_cycle(); settle();
    check("fl_exec_done_late", {31'd0, bus.done}, 32'd0);

    // Flush during COMMIT is ignored
    bus.req_valid = 1'b1; bus.req_op = OpRead; bus.mmu_entryhi_in = 32'hABCD_E002;
    next_cycle();
    bus.req_valid = 1'b0;
    next_cycle();
    bus.flush = 1'b1;
    settle();
    check("fl_commit_done", {31'd0, bus.done}, 32'd1);
    check("fl_commit_entry_we", {31'd0, bus.cp0_entry_we}, 32'd1);
    check("fl_commit_hi", bus.cp0_entryhi_wdata, 32'hABCD_E002);
    next_cycle();
    bus.flush = 1'b0;
    settle();
    check("fl_commit_ready", {31'd0, bus.req_ready}, 32'd1);

    // Random counter with Wired = 30
    wired_in = 5'd30; wired_we = 1'b1;
    next_cycle();
    wired_we = 1'b0;
    settle();
    check("rand_w30_0", random_out, 32'd31);
    next_cycle(); settle();
    check("rand_w30_1", random_out, 32'd30);
    next_cycle(); settle();
    check("rand_w30_2", random_out, 32'd31);
    next_cycle(); settle();
    check("rand_w30_3", random_out, 32'd30);
    wired_in = 5'd10;
    next_cycle(); next_cycle(); settle();
    check("rand_w10_dec", random_out, 32'd28);
    wired_we = 1'b1;
    next_cycle();
    wired_we = 1'b0;
    settle();
    check("rand_wired_we", random_out, 32'd31);
    wired_in = 5'd31;
    next_cycle(); settle();
    check("rand_w31_hold0", random_out, 32'd31);
    next_cycle(); settle();
    check("rand_w31_hold1", random_out, 32'd31);

    // Async reset in the middle of EXEC
    wired_in = 5'd0;
    bus.req_valid = 1'b1; bus.req_op = OpProbe; bus.mmu_index_in = 32'h9;
    next_cycle();
    bus.req_valid = 1'b0;
    settle();
    strobes("arst_pre_strobes", 4'b1000);
    #1 rst_n = 1'b0;
    #1;
    strobes("arst_strobes", 4'b0000);
    check("arst_stall", {31'd0, bus.stall}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_we", {30'd0, bus.cp0_index_we, bus.cp0_entry_we}, 32'd0);
    check("arst_wdata", bus.cp0_index_wdata, 32'd0);
    check("arst_random", random_out, 32'd31);
    next_cycle(); settle();
    check("arst_hold_index_we", {31'd0, bus.cp0_index_we}, 32'd0);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
